// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-port ALU sharing block: ALU control codes, slot FSM states, port id.
package alu_share_pkg;

  // bit3 inverts B and supplies the carry-in, so SUB/SLT are ADD/SLT codes with bit3 set
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_XNOR = 4'b0101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  typedef logic port_id_t;

  function automatic logic is_err_op(input logic [3:0] ctrl);
    return ctrl[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way request arbiter with round-robin memory (rr_last).
// Define ARB_FIXED_PRIO_EN to make port 0 always win a tie; rr_last is then held at 1.
module alu_rr_arb2
  import alu_share_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       slot_free,
  output logic [1:0] grant
);

  port_id_t rr_last_reg;

  always_comb begin
    grant = 2'b00;
    if (slot_free) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = rr_last_reg ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_last_reg <= 1'b1;
    else          rr_last_reg <= 1'b1;
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rr_last_reg <= 1'b1;
    else if (|grant) rr_last_reg <= grant[1];
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// One 32-bit ALU shared by two valid/ready requesters, with a single registered result slot.
// ARB_FIXED_PRIO_EN (optional) selects fixed port-0 priority in the arbiter.
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [TAG_W-1:0]  rsp1_tag
);

  logic [1:0]        req_valid, rsp_ready, grant;
  logic [3:0]        req_ctrl [2];
  logic [DATA_W-1:0] req_a [2];
  logic [DATA_W-1:0] req_b [2];
  logic [TAG_W-1:0]  req_tag [2];

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req_ctrl   = '{req0_ctrl, req1_ctrl};
  assign req_a      = '{req0_a, req1_a};
  assign req_b      = '{req0_b, req1_b};
  assign req_tag    = '{req0_tag, req1_tag};

  state_t     state_reg;
  port_id_t   owner_reg;
  logic [1:0] rsp_valid_reg;
  logic       slot_free, accept;

  // Slot can take a new result when empty or when its owner drains it this cycle
  assign slot_free = reset_n & ((state_reg == ST_IDLE) | rsp_ready[owner_reg]);
  assign accept    = |grant;

  alu_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid     (req_valid),
    .slot_free (slot_free),
    .grant     (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Operand mux and ALU
  port_id_t          sel;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a, alu_b, b_eff, sum, alu_result;
  logic              alu_err;

  assign sel      = grant[1];
  assign alu_ctrl = req_ctrl[sel];
  assign alu_a    = req_a[sel];
  assign alu_b    = req_b[sel];

  always_comb begin
    b_eff      = alu_ctrl[3] ? ~alu_b : alu_b;
    sum        = alu_a + b_eff + {{(DATA_W-1){1'b0}}, alu_ctrl[3]};
    alu_err    = is_err_op(alu_ctrl);
    alu_result = '0;
    unique case (alu_ctrl[2:0])
      3'b000:  alu_result = alu_a & b_eff;
      3'b001:  alu_result = alu_a | b_eff;
      3'b010:  alu_result = sum;
      3'b011:  alu_result = {{(DATA_W-1){1'b0}}, sum[DATA_W-1]};
      3'b100:  alu_result = alu_a ^ b_eff;
      3'b101:  alu_result = ~(alu_a ^ b_eff);
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= 1'b0;
      rsp_valid_reg <= 2'b00;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg     <= ST_FULL;
            owner_reg     <= grant[1];
            rsp_valid_reg <= grant;
          end
        end
        ST_FULL: begin
          if (accept) begin
            owner_reg     <= grant[1];
            rsp_valid_reg <= grant;
          end else if (rsp_ready[owner_reg]) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 2'b00;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Per-port result registers; the non-owner keeps its last value
  logic [DATA_W-1:0] rsp_data_reg [2];
  logic [1:0]        rsp_zero_reg, rsp_err_reg;
  logic [TAG_W-1:0]  rsp_tag_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rsp_data_reg[gi] <= '0;
        rsp_zero_reg[gi] <= 1'b0;
        rsp_err_reg[gi]  <= 1'b0;
        rsp_tag_reg[gi]  <= '0;
      end else if (grant[gi]) begin
        rsp_data_reg[gi] <= alu_result;
        rsp_zero_reg[gi] <= (alu_result == '0);
        rsp_err_reg[gi]  <= alu_err;
        rsp_tag_reg[gi]  <= req_tag[gi];
      end
    end
  end

  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp0_data  = rsp_data_reg[0];
  assign rsp0_zero  = rsp_zero_reg[0];
  assign rsp0_err   = rsp_err_reg[0];
  assign rsp0_tag   = rsp_tag_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp1_data  = rsp_data_reg[1];
  assign rsp1_zero  = rsp_zero_reg[1];
  assign rsp1_err   = rsp_err_reg[1];
  assign rsp1_tag   = rsp_tag_reg[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural slot/arbiter model checked every cycle plus directed literal checks.
module tb_alu_share_arb;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic [3:0]  rsp0_tag, rsp1_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err), .rsp1_tag(rsp1_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_alu_data(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s, d;
    s = a + b;
    d = a - b;
    casez (c)
      4'b0000: return a & b;
      4'b1000: return a & ~b;
      4'b0001: return a | b;
      4'b1001: return a | ~b;
      4'b0010: return s;
      4'b1010: return d;
      4'b0011: return {31'd0, s[31]};
      4'b1011: return {31'd0, d[31]};
      4'b0100: return a ^ b;
      4'b1100: return ~(a ^ b);
      4'b0101: return ~(a ^ b);
      4'b1101: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_alu_err(input logic [3:0] c);
    return (c[2:0] == 3'd6) || (c[2:0] == 3'd7);
  endfunction

  function automatic int pick(input logic v0, input logic v1, input bit free, input int rr);
    if (!free) return -1;
    if (v0 && v1) return FIXED ? 0 : 1 - rr;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  int          m_owner, m_rr, nxt_win;
  logic [31:0] m_data [2];
  logic        m_zero [2];
  logic        m_err [2];
  logic [3:0]  m_tag [2];

  function automatic bit owner_ready(input int owner);
    if (owner == 0) return rsp0_ready;
    if (owner == 1) return rsp1_ready;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      int w;
      w = pick(req0_valid, req1_valid, (m_owner < 0) || owner_ready(m_owner), m_rr);
      check("req0_ready", {31'd0, req0_ready}, {31'd0, w == 0});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, w == 1});
      check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_owner == 0});
      check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_owner == 1});
      check("rsp0_data", rsp0_data, m_data[0]);
      check("rsp1_data", rsp1_data, m_data[1]);
      check("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_zero[0]});
      check("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_zero[1]});
      check("rsp0_err", {31'd0, rsp0_err}, {31'd0, m_err[0]});
      check("rsp1_err", {31'd0, rsp1_err}, {31'd0, m_err[1]});
      check("rsp0_tag", {28'd0, rsp0_tag}, {28'd0, m_tag[0]});
      check("rsp1_tag", {28'd0, rsp1_tag}, {28'd0, m_tag[1]});
      nxt_win <= w;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1;
      m_rr    <= 1;
      nxt_win <= -1;
      for (int i = 0; i < 2; i++) begin
        m_data[i] <= '0; m_zero[i] <= 1'b0; m_err[i] <= 1'b0; m_tag[i] <= '0;
      end
    end else if (nxt_win == 0) begin
      m_data[0] <= m_alu_data(req0_ctrl, req0_a, req0_b);
      m_zero[0] <= m_alu_data(req0_ctrl, req0_a, req0_b) == 32'd0;
      m_err[0]  <= m_alu_err(req0_ctrl);
      m_tag[0]  <= req0_tag;
      m_owner   <= 0;
      m_rr      <= FIXED ? 1 : 0;
    end else if (nxt_win == 1) begin
      m_data[1] <= m_alu_data(req1_ctrl, req1_a, req1_b);
      m_zero[1] <= m_alu_data(req1_ctrl, req1_a, req1_b) == 32'd0;
      m_err[1]  <= m_alu_err(req1_ctrl);
      m_tag[1]  <= req1_tag;
      m_owner   <= 1;
      m_rr      <= 1;
    end else if (m_owner >= 0 && owner_ready(m_owner)) begin
      m_owner <= -1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [4];
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd0;
    req1_valid = 1'b0; req1_ctrl = 4'b0010; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nxt; nxt;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    req0_valid = 1'b0;
    reset_n = 1'b1;
    nxt;

    // port 0 ADD 5+7
    req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
    @(negedge clk);
    check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    nxt;
    req0_valid = 1'b0;
    check("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("add_rsp0_data", rsp0_data, 32'd12);
    check("add_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
    check("add_rsp0_tag", {28'd0, rsp0_tag}, 32'd3);
    nxt;
    $display("[TB] txn add port0 data=%0d tag=%0d", rsp0_data, rsp0_tag);

    // port 1 SLT -1 < 1 with a 3-cycle response stall
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_ctrl = 4'b1011; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_tag = 4'd5;
    @(negedge clk);
    check("slt_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt;
    req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("stall_rsp1_data", rsp1_data, 32'd1);
      check("stall_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      nxt;
    end
    rsp1_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    nxt;
    check("slt_drained_valid", {31'd0, rsp1_valid}, 32'd0);
    check("slt_held_data", rsp1_data, 32'd1);
    $display("[TB] txn slt port1 data=%0d tag=%0d", rsp1_data, rsp1_tag);

    // both valid, SUB 9-9, round robin (or fixed priority)
    exp_g = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
    req0_valid = 1'b1; req0_ctrl = 4'b1010; req0_a = 32'd9; req0_b = 32'd9; req0_tag = 4'hA;
    req1_valid = 1'b1; req1_ctrl = 4'b1010; req1_a = 32'd9; req1_b = 32'd9; req1_tag = 4'hB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_req0_ready", {31'd0, req0_ready}, {31'd0, exp_g[i] == 0});
      check("rr_req1_ready", {31'd0, req1_ready}, {31'd0, exp_g[i] == 1});
      nxt;
      check("rr_rsp_data", exp_g[i] == 0 ? rsp0_data : rsp1_data, 32'd0);
      check("rr_rsp_zero", {31'd0, exp_g[i] == 0 ? rsp0_zero : rsp1_zero}, 32'd1);
      $display("[TB] txn sub grant=%0d data=%0d", exp_g[i], exp_g[i] == 0 ? rsp0_data : rsp1_data);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    nxt;

    // error opcode then back-to-back SLT 3 < 2
    req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd6;
    nxt;
    check("err_data", rsp0_data, 32'd0);
    check("err_zero", {31'd0, rsp0_zero}, 32'd1);
    check("err_err", {31'd0, rsp0_err}, 32'd1);
    $display("[TB] txn err port0 data=%0d err=%0d", rsp0_data, rsp0_err);
    req0_ctrl = 4'b1011; req0_a = 32'd3; req0_b = 32'd2; req0_tag = 4'd7;
    nxt;
    req0_valid = 1'b0;
    check("slt2_data", rsp0_data, 32'd0);
    check("slt2_err", {31'd0, rsp0_err}, 32'd0);
    check("slt2_tag", {28'd0, rsp0_tag}, 32'd7);
    $display("[TB] txn slt port0 data=%0d err=%0d", rsp0_data, rsp0_err);
    nxt;

    // reset while the slot is full
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd2; req0_b = 32'd3; req0_tag = 4'd9;
    nxt;
    check("full_rsp0_data", rsp0_data, 32'd5);
    reset_n = 1'b0;
    #1;
    check("midrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("midrst_rsp0_data", rsp0_data, 32'd0);
    nxt;
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    reset_n = 1'b1;
    nxt;
    check("postrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    req1_valid = 1'b1; req1_ctrl = 4'b0001; req1_a = 32'h0F; req1_b = 32'hF0; req1_tag = 4'd2;
    @(negedge clk);
    check("postrst_req1_ready", {31'd0, req1_ready}, 32'd1);
    nxt;
    req1_valid = 1'b0;
    check("postrst_or_data", rsp1_data, 32'hFF);
    $display("[TB] txn or port1 data=0x%0h tag=%0d", rsp1_data, rsp1_tag);
    nxt; nxt;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
